bcd_modn_counter_04: RTL and testbench

Parametrised multi-digit BCD counter with programmable modulus, up/down direction, count enable, parallel load and a registered wrap pulse. It is the general counting element for the clock datapath: seconds/minutes (MODULO=60), hours (MODULO=24) and 00–99 counters, all cascaded through the wrap pulse.

---
 rtl/bcd_modn_counter_04.sv | 89 ++++++++
 tb/tb_bcd_modn_counter_04.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bcd_modn_counter_04.sv
// bcd_modn_counter_04: multi-digit BCD modulo-N up/down counter with parallel load,
// registered wrap pulse and sticky illegal-load flag.
module bcd_modn_counter_04 #(
    parameter int DIGITS = 2,
    parameter int MODULO = 100
) (
    input  logic                  clk_04,
    input  logic                  rst_04,
    input  logic                  en_04,
    input  logic                  up_04,
    input  logic                  load_04,
    input  logic [4*DIGITS-1:0]   din_04,
    output logic [4*DIGITS-1:0]   dout_04,
    output logic                  cout_04,
    output logic                  err_04
);
    localparam int W = 4*DIGITS;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] TERM = to_bcd(MODULO - 1);

    logic [W-1:0] r_cnt;
    logic         r_cout;
    logic         r_err;
    logic [W-1:0] w_inc;
    logic [W-1:0] w_dec;
    logic         w_legal;
    logic         w_carry;
    logic         w_borrow;

    // Ripple carry/borrow across digits; wrap at the terminal is handled separately,
    // so the increment never has to produce a value past MODULO-1.
    always_comb begin
        w_inc    = r_cnt;
        w_dec    = r_cnt;
        w_legal  = 1'b1;
        w_carry  = 1'b1;
        w_borrow = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_carry) begin
                w_inc[4*k +: 4] = (r_cnt[4*k +: 4] == 4'd9) ? 4'd0 : r_cnt[4*k +: 4] + 4'd1;
                w_carry         = (r_cnt[4*k +: 4] == 4'd9);
            end
            if (w_borrow) begin
                w_dec[4*k +: 4] = (r_cnt[4*k +: 4] == 4'd0) ? 4'd9 : r_cnt[4*k +: 4] - 4'd1;
                w_borrow        = (r_cnt[4*k +: 4] == 4'd0);
            end
            if (din_04[4*k +: 4] > 4'd9) w_legal = 1'b0;
        end
        if (din_04 > TERM) w_legal = 1'b0;
    end

    always_ff @(posedge clk_04) begin
        if (rst_04) begin
            r_cnt  <= '0;
            r_cout <= 1'b0;
            r_err  <= 1'b0;
        end else if (load_04) begin
            r_cnt  <= w_legal ? din_04 : '0;
            r_err  <= ~w_legal;
            r_cout <= 1'b0;
        end else if (en_04) begin
            if (up_04) begin
                r_cnt  <= (r_cnt == TERM) ? '0 : w_inc;
                r_cout <= (r_cnt == TERM);
            end else begin
                r_cnt  <= (r_cnt == '0) ? TERM : w_dec;
                r_cout <= (r_cnt == '0);
            end
        end else begin
            r_cout <= 1'b0;
        end
    end

    assign dout_04 = r_cnt;
    assign cout_04 = r_cout;
    assign err_04  = r_err;
endmodule

// File: tb/tb_bcd_modn_counter_04.sv
// tb_bcd_modn_counter_04: four counter variants (60, 24, 100, 1000) driven in parallel
// and checked against a decimal-arithmetic reference model plus directed vectors.
module tb_bcd_modn_counter_04;
    logic        clk = 1'b0;
    logic        rst = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [11:0] din = '0;
    logic [7:0]  d60, d24, d100;
    logic [11:0] d1000;
    logic        c60, c24, c100, c1000;
    logic        e60, e24, e100, e1000;

    always #5 clk = ~clk;

    bcd_modn_counter_04 #(.DIGITS(2), .MODULO(60)) u60 (
        .clk_04(clk), .rst_04(rst), .en_04(en), .up_04(up), .load_04(load),
        .din_04(din[7:0]), .dout_04(d60), .cout_04(c60), .err_04(e60));
    bcd_modn_counter_04 #(.DIGITS(2), .MODULO(24)) u24 (
        .clk_04(clk), .rst_04(rst), .en_04(en), .up_04(up), .load_04(load),
        .din_04(din[7:0]), .dout_04(d24), .cout_04(c24), .err_04(e24));
    bcd_modn_counter_04 #(.DIGITS(2), .MODULO(100)) u100 (
        .clk_04(clk), .rst_04(rst), .en_04(en), .up_04(up), .load_04(load),
        .din_04(din[7:0]), .dout_04(d100), .cout_04(c100), .err_04(e100));
    bcd_modn_counter_04 #(.DIGITS(3), .MODULO(1000)) u1000 (
        .clk_04(clk), .rst_04(rst), .en_04(en), .up_04(up), .load_04(load),
        .din_04(din), .dout_04(d1000), .cout_04(c1000), .err_04(e1000));

    int n_vec = 0, n_err = 0;
    int mods[4] = '{60, 24, 100, 1000};
    int digs[4] = '{2, 2, 2, 3};
    int m[4];
    bit mc[4], me[4];
    int pc[4];

    function automatic logic [11:0] act_d(int i);
        return (i == 0) ? {4'h0, d60} : (i == 1) ? {4'h0, d24} : (i == 2) ? {4'h0, d100} : d1000;
    endfunction
    function automatic logic act_c(int i);
        return (i == 0) ? c60 : (i == 1) ? c24 : (i == 2) ? c100 : c1000;
    endfunction
    function automatic logic act_e(int i);
        return (i == 0) ? e60 : (i == 1) ? e24 : (i == 2) ? e100 : e1000;
    endfunction

    function automatic logic [11:0] to_bcd(int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: decimal integers, wrap by modulo arithmetic.
    task automatic model_edge();
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                m[i] = 0; mc[i] = 0; me[i] = 0;
            end else if (load) begin
                int v = 0, p = 1;
                bit ok = 1;
                for (int k = 0; k < digs[i]; k++) begin
                    if (din[4*k +: 4] > 9) ok = 0;
                    v += int'(din[4*k +: 4]) * p;
                    p *= 10;
                end
                if (v >= mods[i]) ok = 0;
                m[i] = ok ? v : 0; me[i] = !ok; mc[i] = 0;
            end else if (en) begin
                mc[i] = up ? (m[i] == mods[i] - 1) : (m[i] == 0);
                m[i] = up ? (m[i] + 1) % mods[i] : (m[i] + mods[i] - 1) % mods[i];
            end else begin
                mc[i] = 0;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dout[mod%0d]", mods[i]), 32'(act_d(i)), 32'(to_bcd(m[i])));
            chk($sformatf("cout[mod%0d]", mods[i]), 32'(act_c(i)), 32'(mc[i]));
            chk($sformatf("err[mod%0d]", mods[i]), 32'(act_e(i)), 32'(me[i]));
            if (act_c(i) === 1'b1) pc[i]++;
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic l, input logic [11:0] d);
        rst = r; en = e; up = u; load = l; din = d;
    endtask

    typedef struct {
        logic r, e, u, l;
        logic [11:0] d;
        logic [7:0] x_d;
        logic x_c, x_e;
    } vec_t;

    vec_t tv[14];

    initial begin
        tv[0]  = '{1, 0, 1, 0, 12'h000, 8'h00, 0, 0};
        tv[1]  = '{0, 0, 1, 1, 12'h001, 8'h01, 0, 0};
        tv[2]  = '{0, 1, 0, 0, 12'h000, 8'h00, 0, 0};
        tv[3]  = '{0, 1, 0, 0, 12'h000, 8'h59, 1, 0};
        tv[4]  = '{0, 1, 0, 0, 12'h000, 8'h58, 0, 0};
        tv[5]  = '{0, 1, 1, 0, 12'h000, 8'h59, 0, 0};
        tv[6]  = '{0, 0, 1, 1, 12'h07A, 8'h00, 0, 1};
        tv[7]  = '{0, 1, 1, 0, 12'h000, 8'h01, 0, 1};
        tv[8]  = '{0, 1, 1, 0, 12'h000, 8'h02, 0, 1};
        tv[9]  = '{0, 0, 1, 1, 12'h045, 8'h45, 0, 0};
        tv[10] = '{0, 0, 1, 1, 12'h059, 8'h59, 0, 0};
        tv[11] = '{0, 1, 1, 1, 12'h030, 8'h30, 0, 0};
        tv[12] = '{0, 0, 1, 1, 12'h059, 8'h59, 0, 0};
        tv[13] = '{1, 1, 1, 0, 12'h000, 8'h00, 0, 0};

        foreach (tv[i]) begin
            drive(tv[i].r, tv[i].e, tv[i].u, tv[i].l, tv[i].d);
            step();
            chk($sformatf("tbl%0d dout", i), 32'(d60), 32'(tv[i].x_d));
            chk($sformatf("tbl%0d cout", i), 32'(c60), 32'(tv[i].x_c));
            chk($sformatf("tbl%0d err", i), 32'(e60), 32'(tv[i].x_e));
        end

        // Up wrap over 61 edges at MODULO=60
        drive(1, 0, 1, 0, 0); step();
        pc = '{0, 0, 0, 0};
        drive(0, 1, 1, 0, 0);
        for (int i = 1; i <= 61; i++) begin
            step();
            if (i == 10) chk("rollover 09->10", 32'(d60), 32'h10);
            if (i == 60) chk("wrap60 cout", 32'(c60), 32'(1));
        end
        chk("wrap60 pulses", 32'(pc[0]), 32'(1));
        chk("wrap60 final", 32'(d60), 32'h01);

        // Hours: 22 -> 23 -> 00 (pulse) -> 01
        drive(0, 0, 1, 1, 12'h022); step();
        drive(0, 1, 1, 0, 0);
        step(); chk("hrs 23", 32'(d24), 32'h23);
        step(); chk("hrs 00", 32'(d24), 32'h00); chk("hrs cout", 32'(c24), 32'(1));
        step(); chk("hrs 01", 32'(d24), 32'h01); chk("hrs cout off", 32'(c24), 32'(0));

        // Full cycles up and down for 100 and 1000
        drive(1, 0, 1, 0, 0); step();
        pc = '{0, 0, 0, 0};
        drive(0, 1, 1, 0, 0);
        repeat (1000) step();
        chk("full up p1000", 32'(pc[3]), 32'(1));
        chk("full up p100", 32'(pc[2]), 32'(10));
        chk("full up d1000", 32'(d1000), 32'h000);
        pc = '{0, 0, 0, 0};
        drive(0, 1, 0, 0, 0);
        step();
        chk("down wrap 999", 32'(d1000), 32'h999);
        chk("down wrap 99", 32'(d100), 32'h99);
        repeat (999) step();
        chk("full dn p1000", 32'(pc[3]), 32'(1));
        chk("full dn p100", 32'(pc[2]), 32'(10));
        chk("full dn d1000", 32'(d1000), 32'h000);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] d;
            for (int k = 0; k < 3; k++)
                d[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                  ($urandom_range(0, 15) == 0), d);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
